// File: rtl/wave_gen_pkg.sv
// Shared types for the wave_gen waveform generator: waveform mode and ramp direction.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    WM_TRI    = 2'd0,
    WM_SAW_UP = 2'd1,
    WM_SAW_DN = 2'd2,
    WM_SQUARE = 2'd3
  } wave_mode_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } wave_dir_t;

endpackage

// File: rtl/wave_gen_step.sv
// Combinational saturating phase step: up clamps at limit, down clamps at zero.
module wave_gen_step
  import wave_gen_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] phase,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  wave_dir_t        dir,
  output logic [WIDTH-1:0] nxt_phase,
  output logic             at_limit
);

  logic [WIDTH:0] sum_s;

  // One extra bit on the sum so the clamp never sees a wrapped value.
  always_comb begin
    sum_s     = {1'b0, phase} + {1'b0, step};
    nxt_phase = phase;
    at_limit  = 1'b0;
    if (dir == DIR_UP) begin
      if (sum_s >= {1'b0, limit}) begin
        nxt_phase = limit;
        at_limit  = 1'b1;
      end else begin
        nxt_phase = sum_s[WIDTH-1:0];
        at_limit  = 1'b0;
      end
    end else begin
      if (phase <= step) begin
        nxt_phase = '0;
        at_limit  = 1'b1;
      end else begin
        nxt_phase = phase - step;
        at_limit  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wave_gen.sv
// Periodic waveform generator (triangle, sawtooth up/down, square) with period strobe.
// Optional amplitude limit port enabled by macro WAVE_GEN_PEAK_EN.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
`ifdef WAVE_GEN_PEAK_EN
  input  logic [WIDTH-1:0] peak,
`endif
  output logic [WIDTH-1:0] wave,
  output logic             period_done
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] phase_r, step_r, p_r, wave_r;
  wave_dir_t        dir_r;
  wave_mode_t       mode_r;
  logic             pd_r;

  logic [WIDTH-1:0] peak_s, step_in_s, stp_phase_s;
  logic [WIDTH-1:0] phase_nxt_s, step_nxt_s, p_nxt_s, wave_nxt_s;
  wave_dir_t        dir_nxt_s, stp_dir_s;
  wave_mode_t       mode_in_s, mode_nxt_s;
  logic             at_limit_s, boundary_s, load_s, pd_nxt_s;

`ifdef WAVE_GEN_PEAK_EN
  assign peak_s = peak;
`else
  assign peak_s = MAX;
`endif

  assign step_in_s = (step == '0) ? ONE : step;
  assign mode_in_s = wave_mode_t'(mode);
  // Sawtooth modes share the up ramp; sawtooth down is mapped as P - phase.
  assign stp_dir_s = ((mode_r == WM_TRI) || (mode_r == WM_SQUARE)) ? dir_r : DIR_UP;

  wave_gen_step #(.WIDTH(WIDTH)) u_step (
    .phase     (phase_r),
    .step      (step_r),
    .limit     (p_r),
    .dir       (stp_dir_s),
    .nxt_phase (stp_phase_s),
    .at_limit  (at_limit_s)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= '0;
      dir_r   <= DIR_UP;
      mode_r  <= WM_TRI;
      step_r  <= ONE;
      p_r     <= MAX;
      wave_r  <= '0;
      pd_r    <= 1'b0;
    end else begin
      phase_r <= phase_nxt_s;
      dir_r   <= dir_nxt_s;
      mode_r  <= mode_nxt_s;
      step_r  <= step_nxt_s;
      p_r     <= p_nxt_s;
      wave_r  <= wave_nxt_s;
      pd_r    <= pd_nxt_s;
    end
  end

  // Next phase/direction, boundary detection and configuration reload.
  always_comb begin
    phase_nxt_s = phase_r;
    dir_nxt_s   = dir_r;
    boundary_s  = 1'b0;
    if (!en) begin
      phase_nxt_s = '0;
      dir_nxt_s   = DIR_UP;
    end else if (p_r == '0) begin
      phase_nxt_s = '0;
      dir_nxt_s   = DIR_UP;
      boundary_s  = 1'b1;
    end else begin
      case (mode_r)
        WM_TRI, WM_SQUARE: begin
          phase_nxt_s = stp_phase_s;
          if (dir_r == DIR_UP) begin
            dir_nxt_s = at_limit_s ? DIR_DN : DIR_UP;
          end else if (at_limit_s) begin
            dir_nxt_s  = DIR_UP;
            boundary_s = 1'b1;
          end else begin
            dir_nxt_s = DIR_DN;
          end
        end
        WM_SAW_UP, WM_SAW_DN: begin
          dir_nxt_s = DIR_UP;
          if (phase_r == p_r) begin
            phase_nxt_s = '0;
            boundary_s  = 1'b1;
          end else begin
            phase_nxt_s = stp_phase_s;
          end
        end
        default: begin
          phase_nxt_s = '0;
          dir_nxt_s   = DIR_UP;
        end
      endcase
    end
    load_s     = !en || boundary_s;
    mode_nxt_s = load_s ? mode_in_s : mode_r;
    step_nxt_s = load_s ? step_in_s : step_r;
    p_nxt_s    = load_s ? peak_s    : p_r;
  end

  // Sample mapping; a boundary sample already belongs to the newly latched configuration.
  always_comb begin
    wave_nxt_s = '0;
    pd_nxt_s   = 1'b0;
    if (!en) begin
      wave_nxt_s = (mode_in_s == WM_SAW_DN) ? peak_s : '0;
      pd_nxt_s   = 1'b0;
    end else begin
      pd_nxt_s = boundary_s;
      case (mode_nxt_s)
        WM_TRI, WM_SAW_UP: wave_nxt_s = phase_nxt_s;
        WM_SAW_DN:         wave_nxt_s = p_nxt_s - phase_nxt_s;
        WM_SQUARE:         wave_nxt_s = (dir_nxt_s == DIR_UP) ? p_nxt_s : '0;
        default:           wave_nxt_s = '0;
      endcase
    end
  end

  assign wave        = wave_r;
  assign period_done = pd_r;

endmodule

// File: tb/tb_wave_gen.sv
// Directed self-checking bench for wave_gen (WIDTH=5); peak tests need WAVE_GEN_PEAK_EN.
module tb_wave_gen;
  import wave_gen_pkg::*;

  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             rst_n, en, period_done;
  logic [1:0]       mode;
  logic [WIDTH-1:0] step, wave;
`ifdef WAVE_GEN_PEAK_EN
  logic [WIDTH-1:0] peak;
  int               pk_exp [7] = '{4, 8, 10, 6, 2, 0, 4};
`endif

  int checks   = 0;
  int failures = 0;
  int exp_w, t, j;

  always #5 clk = ~clk;

  wave_gen #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .step        (step),
`ifdef WAVE_GEN_PEAK_EN
    .peak        (peak),
`endif
    .wave        (wave),
    .period_done (period_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int exp_wave, input logic exp_pd);
    chk({tag, "_wave"}, {27'd0, wave}, exp_wave);
    chk({tag, "_pd"}, {31'd0, period_done}, {31'd0, exp_pd});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; step = 5'd1;
`ifdef WAVE_GEN_PEAK_EN
    peak = 5'd31;
`endif
    #3;
    chk_out("reset", 0, 1'b0);
    tick; tick;
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Triangle, full scale, step 1: two periods of 62.
    for (int k = 1; k <= 124; k++) begin
      tick;
      t = k % 62;
      exp_w = (t <= 31) ? t : 62 - t;
      chk_out("tri", exp_w, t == 0);
    end

    // Square requested mid-period: takes effect at the triangle boundary.
    for (int k = 125; k <= 248; k++) begin
      if (k == 134) mode = 2'd3;
      tick;
      t = k - 124;
      if (k < 186)       exp_w = (t <= 31) ? t : 62 - t;
      else if (k <= 216) exp_w = 31;
      else if (k <= 247) exp_w = 0;
      else               exp_w = 31;
      chk_out("tri2sq", exp_w, (k == 186) || (k == 248));
    end

    // Sawtooth up, step 3: period 12.
    en = 1'b0; mode = 2'd1; step = 5'd3;
    tick;
    chk_out("saw_hold", 0, 1'b0);
    en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick;
      j = k % 12;
      exp_w = (j == 0) ? 0 : ((j == 11) ? 31 : 3 * j);
      chk_out("sawup", exp_w, j == 0);
    end

    // Triangle to 17, drop en, restart as sawtooth down.
    en = 1'b0; mode = 2'd0; step = 5'd1;
    tick;
    en = 1'b1;
    for (int k = 1; k <= 17; k++) tick;
    chk_out("at17", 17, 1'b0);
    en = 1'b0; mode = 2'd2;
    tick;
    chk_out("dn_hold1", 31, 1'b0);
    tick;
    chk_out("dn_hold2", 31, 1'b0);
    en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick;
      exp_w = (k < 32) ? 31 - k : 31;
      chk_out("sawdn", exp_w, k == 32);
    end

    // Asynchronous reset while the triangle is descending.
    en = 1'b0; mode = 2'd0; step = 5'd1;
    tick;
    en = 1'b1;
    for (int k = 1; k <= 35; k++) tick;
    chk_out("pre_rst", 27, 1'b0);
    chk("pre_rst_dir", {31'd0, dut.dir_r}, {31'd0, DIR_DN});
    #2 rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 0, 1'b0);
    chk("mid_rst_dir", {31'd0, dut.dir_r}, {31'd0, DIR_UP});
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk_out("restart", k, 1'b0);
    end

    // Step 0 behaves as step 1.
    en = 1'b0; mode = 2'd1; step = 5'd0;
    tick;
    en = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick;
      chk_out("step0", k, 1'b0);
    end

`ifdef WAVE_GEN_PEAK_EN
    en = 1'b0; mode = 2'd0; step = 5'd4; peak = 5'd10;
    tick;
    chk_out("pk_hold", 0, 1'b0);
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick;
      chk_out("pk10", pk_exp[k], k == 5);
    end
    en = 1'b0; peak = 5'd0;
    tick;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk_out("pk0", 0, 1'b1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
